mem_stage: RTL and testbench

//  Load/store stage behind decode/execute in the RV32I core.
//  - Accepts one load or store per handshake.
//  - Drives the core's RAM data port: read request/address, write enable, byte enables, write address/data.
//  - Aligns and extends load data, then returns it to the register-file writeback.
//  - Flags misaligned or illegal accesses instead of issuing them to RAM.

---
 rtl/mem_stage.sv | 179 +++++++++++++++++
 tb/tb_mem_stage.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Load/store stage of the RV32I core: issues RAM reads and writes for one
// request at a time, aligns and extends load data for writeback, and
// reports misaligned or illegal accesses without touching RAM.
module mem_stage #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_is_load,
  input  logic                  i_is_store,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH:0]   i_addr,
  input  logic [DATA_WIDTH:0]   i_store_data,
  input  logic [4:0]            i_rd,
  output logic                  o_read_req,
  output logic [ADDR_WIDTH:0]   o_read_addr,
  input  logic [DATA_WIDTH:0]   i_read_data,
  input  logic                  i_read_ready,
  output logic                  o_write_enable,
  output logic [3:0]            o_byte_enable,
  output logic [ADDR_WIDTH:0]   o_write_addr,
  output logic [DATA_WIDTH:0]   o_write_data,
  output logic                  o_wb_valid,
  output logic [4:0]            o_wb_rd,
  output logic [DATA_WIDTH:0]   o_wb_data,
  output logic                  o_fault
);

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE = 2'd0, STORE = 2'd1, LOAD_WAIT = 2'd2} state_t;

  state_t       state_p1, state_d;
  logic         accept_p0;
  logic         fault_p0;
  logic [1:0]   off_p1;
  logic [2:0]   f3_p1;
  logic [4:0]   rd_p1;

  // Illegal kind, unsupported width code, or address not aligned to the access size.
  function automatic logic access_fault(input logic is_load, input logic is_store,
                                        input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (is_load == is_store)
      bad = 1'b1;
    else if (is_store)
      bad = (f3 > 3'd2);
    else
      bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    if ((f3[1:0] == 2'd1) && off[0])
      bad = 1'b1;
    if ((f3[1:0] == 2'd2) && (off != 2'd0))
      bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'd0:    return 4'b0001 << off;
      2'd1:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  function automatic logic [DATA_WIDTH:0] store_lanes(input logic [2:0] f3,
                                                      input logic [DATA_WIDTH:0] d);
    case (f3[1:0])
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH:0] load_extend(input logic [2:0] f3,
                                                      input logic [1:0] off,
                                                      input logic [DATA_WIDTH:0] word);
    logic        [DATA_WIDTH:0] shifted;
    logic signed [7:0]          byte_s;
    logic signed [15:0]         half_s;
    logic signed [DATA_WIDTH:0] ext_s;
    shifted = word >> {off, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = shifted[15:0];
    case (f3)
      F3_B:    ext_s = (DATA_WIDTH+1)'(byte_s);
      F3_H:    ext_s = (DATA_WIDTH+1)'(half_s);
      F3_BU:   ext_s = (DATA_WIDTH+1)'(shifted[7:0]);
      F3_HU:   ext_s = (DATA_WIDTH+1)'(shifted[15:0]);
      default: ext_s = shifted;
    endcase
    return ext_s;
  endfunction

  assign o_ready   = (state_p1 == IDLE);
  assign accept_p0 = i_valid && o_ready && clk_en;
  assign fault_p0  = access_fault(i_is_load, i_is_store, i_funct3, i_addr[1:0]);

  // Next-state selection; accepted legal requests leave IDLE, others stay.
  always_comb begin
    state_d = state_p1;
    case (state_p1)
      IDLE: begin
        if (accept_p0 && !fault_p0)
          state_d = i_is_store ? STORE : LOAD_WAIT;
      end
      STORE:     state_d = IDLE;
      LOAD_WAIT: if (i_read_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State register, advanced only on enabled cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_p1 <= IDLE;
    else if (clk_en)
      state_p1 <= state_d;
  end

  // Stage p0 -> p1: RAM port, latched load context, writeback and fault outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_read_req     <= 1'b0;
      o_read_addr    <= '0;
      o_write_enable <= 1'b0;
      o_byte_enable  <= 4'b0000;
      o_write_addr   <= '0;
      o_write_data   <= '0;
      o_wb_valid     <= 1'b0;
      o_wb_rd        <= 5'd0;
      o_wb_data      <= '0;
      o_fault        <= 1'b0;
      off_p1         <= 2'd0;
      f3_p1          <= 3'd0;
      rd_p1          <= 5'd0;
    end else if (clk_en) begin
      o_fault    <= accept_p0 && fault_p0;
      o_wb_valid <= 1'b0;
      case (state_p1)
        IDLE: begin
          if (accept_p0 && !fault_p0) begin
            if (i_is_store) begin
              o_write_enable <= 1'b1;
              o_write_addr   <= {i_addr[ADDR_WIDTH:2], 2'b00};
              o_byte_enable  <= store_be(i_funct3, i_addr[1:0]);
              o_write_data   <= store_lanes(i_funct3, i_store_data);
            end else begin
              o_read_req  <= 1'b1;
              o_read_addr <= {i_addr[ADDR_WIDTH:2], 2'b00};
              off_p1      <= i_addr[1:0];
              f3_p1       <= i_funct3;
              rd_p1       <= i_rd;
            end
          end
        end
        STORE: o_write_enable <= 1'b0;
        LOAD_WAIT: begin
          if (i_read_ready) begin
            o_read_req <= 1'b0;
            o_wb_valid <= 1'b1;
            o_wb_rd    <= rd_p1;
            o_wb_data  <= load_extend(f3_p1, off_p1, i_read_data);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized loads/stores
// checked against a byte-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        i_valid;
  logic        o_ready;
  logic        i_is_load;
  logic        i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_store_data;
  logic [4:0]  i_rd;
  logic        o_read_req;
  logic [31:0] o_read_addr;
  logic [31:0] i_read_data;
  logic        i_read_ready;
  logic        o_write_enable;
  logic [3:0]  o_byte_enable;
  logic [31:0] o_write_addr;
  logic [31:0] o_write_data;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_fault;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_is_load(i_is_load), .i_is_store(i_is_store), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_store_data(i_store_data), .i_rd(i_rd),
    .o_read_req(o_read_req), .o_read_addr(o_read_addr),
    .i_read_data(i_read_data), .i_read_ready(i_read_ready),
    .o_write_enable(o_write_enable), .o_byte_enable(o_byte_enable),
    .o_write_addr(o_write_addr), .o_write_data(o_write_data),
    .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
    .o_fault(o_fault)
  );

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    int k;
    k = f3 % 4;
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic bit exp_fault(input bit ld, input bit st, input logic [2:0] f3,
                                   input logic [31:0] a);
    if (ld == st) return 1;
    if (st && f3 > 2) return 1;
    if (ld && (f3 == 3 || f3 == 6 || f3 == 7)) return 1;
    return (a % acc_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be;
    be = 4'b0000;
    for (int i = 0; i < acc_size(f3); i++) be = be | 4'(1 << ((a % 4) + i));
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    w = 32'd0;
    for (int lane = 0; lane < 4; lane++)
      w = w | (((d >> (8 * (lane % acc_size(f3)))) & 32'hFF) << (8 * lane));
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
    longint v;
    int sz;
    sz = acc_size(f3);
    v = (longint'(word) >> (8 * (a % 4))) & ((64'd1 << (8 * sz)) - 1);
    if (f3 < 4 && sz < 4 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    i_valid = 1'b1; i_is_load = ld; i_is_store = st; i_funct3 = f3;
    i_addr = a; i_store_data = d; i_rd = rd;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; clk_en = 1'b1; i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
    i_funct3 = 3'd0; i_addr = 32'd0; i_store_data = 32'd0; i_rd = 5'd0;
    i_read_data = 32'd0; i_read_ready = 1'b0;
    repeat (2) step();
    for (int pass = 0; pass < 2; pass++) begin
      checks++;
      if (o_ready !== 1'b1) begin
        failures++; $display("FAIL reset_ready pass=%0d got=%b exp=1", pass, o_ready);
      end
      checks++;
      if ({o_read_req, o_write_enable, o_byte_enable, o_wb_valid, o_fault, o_wb_rd} !== 13'd0) begin
        failures++;
        $display("FAIL reset_ctrl pass=%0d got=%b exp=0", pass,
                 {o_read_req, o_write_enable, o_byte_enable, o_wb_valid, o_fault, o_wb_rd});
      end
      checks++;
      if ({o_read_addr, o_write_addr, o_write_data, o_wb_data} !== 128'd0) begin
        failures++; $display("FAIL reset_data pass=%0d got=%h exp=0", pass,
                             {o_read_addr, o_write_addr, o_write_data, o_wb_data});
      end
      rst = 1'b1;
      step();
    end
  endtask

  task automatic test_store_directed();
    logic [31:0] da [2] = '{32'hDEADBEEF, 32'h000000A5};
    logic [31:0] aa [2] = '{32'h100, 32'h203};
    logic [2:0]  fa [2] = '{3'd2, 3'd0};
    logic [3:0]  be_x [2] = '{4'b1111, 4'b1000};
    logic [31:0] wa_x [2] = '{32'h100, 32'h200};
    logic [31:0] wd_x [2] = '{32'hDEADBEEF, 32'hA5A5A5A5};
    for (int t = 0; t < 2; t++) begin
      present(0, 1, fa[t], aa[t], da[t], 5'd0);
      step();
      i_valid = 1'b0;
      checks++;
      if ({o_write_enable, o_byte_enable, o_write_addr, o_write_data, o_ready, o_read_req} !==
          {1'b1, be_x[t], wa_x[t], wd_x[t], 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL store_dir%0d got we=%b be=%b wa=%h wd=%h rdy=%b rr=%b exp be=%b wa=%h wd=%h",
                 t, o_write_enable, o_byte_enable, o_write_addr, o_write_data, o_ready,
                 o_read_req, be_x[t], wa_x[t], wd_x[t]);
      end
      step();
      checks++;
      if ({o_write_enable, o_ready} !== 2'b01) begin
        failures++; $display("FAIL store_dir%0d_end got we=%b rdy=%b exp we=0 rdy=1",
                             t, o_write_enable, o_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    present(0, 1, 3'd2, 32'h40, 32'h11223344, 5'd0);
    step();
    present(0, 1, 3'd1, 32'h10A, 32'h00001234, 5'd0);
    step();
    checks++;
    if ({o_write_enable, o_ready} !== 2'b01) begin
      failures++; $display("FAIL b2b_hold got we=%b rdy=%b exp we=0 rdy=1", o_write_enable, o_ready);
    end
    step();
    i_valid = 1'b0;
    checks++;
    if ({o_write_enable, o_byte_enable, o_write_addr, o_write_data} !==
        {1'b1, 4'b1100, 32'h108, 32'h12341234}) begin
      failures++; $display("FAIL b2b_second got we=%b be=%b wa=%h wd=%h exp 1 1100 108 12341234",
                           o_write_enable, o_byte_enable, o_write_addr, o_write_data);
    end
    step();
  endtask

  task automatic test_load_directed();
    logic [2:0]  fa [2] = '{3'd0, 3'd4};
    logic [31:0] xa [2] = '{32'hFFFFFFF0, 32'h000000F0};
    int high;
    for (int t = 0; t < 2; t++) begin
      present(1, 0, fa[t], 32'h102, 32'd0, 5'd5);
      i_read_data = 32'h12F03456;
      step();
      i_valid = 1'b0;
      high = 0;
      for (int w = 0; w < 4; w++) begin
        if (o_read_req === 1'b1 && o_read_addr === 32'h100 && o_write_enable === 1'b0) high++;
        if (w < 3) step();
      end
      checks++;
      if (high != 4) begin
        failures++; $display("FAIL load_dir%0d_req got=%0d cycles exp=4", t, high);
      end
      i_read_ready = 1'b1;
      step();
      i_read_ready = 1'b0;
      checks++;
      if ({o_wb_valid, o_wb_rd, o_wb_data, o_read_req, o_ready} !== {1'b1, 5'd5, xa[t], 1'b0, 1'b1}) begin
        failures++; $display("FAIL load_dir%0d_wb got v=%b rd=%0d d=%h rr=%b exp v=1 rd=5 d=%h",
                             t, o_wb_valid, o_wb_rd, o_wb_data, o_read_req, xa[t]);
      end
      step();
      checks++;
      if ({o_wb_valid, o_wb_data} !== {1'b0, xa[t]}) begin
        failures++; $display("FAIL load_dir%0d_hold got v=%b d=%h exp v=0 d=%h",
                             t, o_wb_valid, o_wb_data, xa[t]);
      end
    end
  endtask

  task automatic test_faults();
    bit          ld [3] = '{1, 0, 1};
    bit          st [3] = '{0, 1, 0};
    logic [2:0]  fa [3] = '{3'd1, 3'd2, 3'd3};
    logic [31:0] aa [3] = '{32'h101, 32'h102, 32'h0};
    bit ef;
    for (int t = 0; t < 3; t++) begin
      ef = exp_fault(ld[t], st[t], fa[t], aa[t]);
      present(ld[t], st[t], fa[t], aa[t], 32'hCAFEF00D, 5'd3);
      step();
      i_valid = 1'b0;
      checks++;
      if ({o_fault, o_read_req, o_write_enable, o_ready} !== {ef, 1'b0, 1'b0, 1'b1}) begin
        failures++; $display("FAIL fault%0d got f=%b rr=%b we=%b rdy=%b exp f=%b rr=0 we=0 rdy=1",
                             t, o_fault, o_read_req, o_write_enable, o_ready, ef);
      end
      step();
      checks++;
      if ({o_fault, o_read_req, o_write_enable} !== 3'b000) begin
        failures++; $display("FAIL fault%0d_pulse got f=%b rr=%b we=%b exp 000",
                             t, o_fault, o_read_req, o_write_enable);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    present(1, 0, 3'd2, 32'h40, 32'd0, 5'd7);
    step();
    i_valid = 1'b0;
    step();
    checks++;
    if (o_read_req !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pending got rr=%b exp=1", o_read_req);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({o_read_req, o_ready} !== 2'b01) begin
      failures++; $display("FAIL rst_mid_async got rr=%b rdy=%b exp rr=0 rdy=1", o_read_req, o_ready);
    end
    step();
    rst = 1'b1;
    i_read_data = 32'h55AA55AA;
    i_read_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({o_wb_valid, o_read_req, o_ready} !== 3'b001) begin
        failures++; $display("FAIL rst_mid_ignore%0d got v=%b rr=%b rdy=%b exp 0 0 1",
                             c, o_wb_valid, o_read_req, o_ready);
      end
    end
    i_read_ready = 1'b0;
  endtask

  task automatic test_clk_en();
    present(1, 0, 3'd5, 32'h2, 32'd0, 5'd9);
    step();
    i_valid = 1'b0;
    i_read_data = 32'hBEEF0000;
    i_read_ready = 1'b1;
    clk_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if ({o_wb_valid, o_read_req, o_ready} !== 3'b010) begin
        failures++; $display("FAIL clken_frozen%0d got v=%b rr=%b rdy=%b exp 0 1 0",
                             c, o_wb_valid, o_read_req, o_ready);
      end
    end
    clk_en = 1'b1;
    step();
    i_read_ready = 1'b0;
    checks++;
    if ({o_wb_valid, o_wb_rd, o_wb_data} !== {1'b1, 5'd9, 32'h0000BEEF}) begin
      failures++; $display("FAIL clken_wb got v=%b rd=%0d d=%h exp v=1 rd=9 d=0000beef",
                           o_wb_valid, o_wb_rd, o_wb_data);
    end
    step();
    checks++;
    if (o_wb_valid !== 1'b0) begin
      failures++; $display("FAIL clken_single got v=%b exp=0", o_wb_valid);
    end
  endtask

  task automatic test_random();
    bit ld, st, ef;
    int kind, waits;
    logic [2:0]  f3;
    logic [31:0] a, d, rw, xl;
    logic [4:0]  rd;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      ld = (kind < 5) || (kind == 9 && $urandom_range(0, 1) == 1);
      st = (kind >= 5 && kind < 9) || (kind == 9 && ld);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom; d = $urandom; rw = $urandom; rd = 5'($urandom);
      ef = exp_fault(ld, st, f3, a);
      if ($urandom_range(0, 3) == 0) begin
        i_read_ready = 1'b1;
        step();
        i_read_ready = 1'b0;
        checks++;
        if (o_wb_valid !== 1'b0) begin
          failures++; $display("FAIL rnd%0d_stray_ready got v=%b exp=0", n, o_wb_valid);
        end
      end
      present(ld, st, f3, a, d, rd);
      step();
      i_valid = 1'b0;
      if (ef) begin
        checks++;
        if ({o_fault, o_read_req, o_write_enable} !== 3'b100) begin
          failures++; $display("FAIL rnd%0d_fault got f=%b rr=%b we=%b exp 100 (ld=%b st=%b f3=%0d a=%h)",
                               n, o_fault, o_read_req, o_write_enable, ld, st, f3, a);
        end
        step();
      end else if (st) begin
        checks++;
        if ({o_fault, o_read_req, o_write_enable, o_byte_enable, o_write_addr, o_write_data} !==
            {1'b0, 1'b0, 1'b1, exp_be(f3, a), a & 32'hFFFFFFFC, exp_wdata(f3, d)}) begin
          failures++; $display("FAIL rnd%0d_store got we=%b be=%b wa=%h wd=%h exp be=%b wa=%h wd=%h",
                               n, o_write_enable, o_byte_enable, o_write_addr, o_write_data,
                               exp_be(f3, a), a & 32'hFFFFFFFC, exp_wdata(f3, d));
        end
        step();
      end else begin
        waits = $urandom_range(0, 3);
        i_read_data = rw;
        for (int w = 0; w <= waits; w++) begin
          checks++;
          if ({o_read_req, o_write_enable, o_read_addr, o_fault} !== {1'b1, 1'b0, a & 32'hFFFFFFFC, 1'b0}) begin
            failures++; $display("FAIL rnd%0d_readreq got rr=%b we=%b ra=%h f=%b exp rr=1 ra=%h",
                                 n, o_read_req, o_write_enable, o_read_addr, o_fault, a & 32'hFFFFFFFC);
          end
          if (w == waits) i_read_ready = 1'b1;
          step();
        end
        i_read_ready = 1'b0;
        xl = exp_load(f3, a, rw);
        checks++;
        if ({o_wb_valid, o_wb_rd, o_wb_data, o_read_req} !== {1'b1, rd, xl, 1'b0}) begin
          failures++; $display("FAIL rnd%0d_load got v=%b rd=%0d d=%h rr=%b exp rd=%0d d=%h (f3=%0d a=%h w=%h)",
                               n, o_wb_valid, o_wb_rd, o_wb_data, o_read_req, rd, xl, f3, a, rw);
        end
        step();
      end
      checks++;
      if ({o_ready, o_write_enable, o_read_req, o_wb_valid, o_fault} !== 5'b10000) begin
        failures++; $display("FAIL rnd%0d_idle got rdy=%b we=%b rr=%b v=%b f=%b exp 10000",
                             n, o_ready, o_write_enable, o_read_req, o_wb_valid, o_fault);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_directed();
    test_back_to_back();
    test_load_directed();
    test_faults();
    test_reset_mid_load();
    test_clk_en();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
